// File: rtl/support_wb_arbiter.sv
// Two-master round-robin arbiter for the 16-slot support-IO Wishbone bus.
// Registers the winning request, decodes a one-hot slave strobe, and forces completion on timeout.
module support_wb_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clk_i,
    input  logic         nreset_i,

    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic [7:0]   m0_adr_i,
    input  logic [7:0]   m0_dat_i,
    output logic [7:0]   m0_dat_o,
    output logic         m0_ack_o,
    output logic         m0_err_o,

    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [7:0]   m1_adr_i,
    input  logic [7:0]   m1_dat_i,
    output logic [7:0]   m1_dat_o,
    output logic         m1_ack_o,
    output logic         m1_err_o,

    output logic [15:0]  stb_o,
    output logic         we_o,
    output logic [7:0]   adr_o,
    output logic [7:0]   dat_o,
    input  logic [127:0] dat_i,
    input  logic         ack_i,
    output logic [1:0]   grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_last, w_last_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic [15:0]      r_stb, w_stb_nxt;
    logic             r_we, w_we_nxt;
    logic [7:0]       r_adr, w_adr_nxt;
    logic [7:0]       r_dat, w_dat_nxt;
    logic [7:0]       r_m0_dat, w_m0_dat_nxt;
    logic             r_m0_ack, w_m0_ack_nxt;
    logic             r_m0_err, w_m0_err_nxt;
    logic [7:0]       r_m1_dat, w_m1_dat_nxt;
    logic             r_m1_ack, w_m1_ack_nxt;
    logic             r_m1_err, w_m1_err_nxt;

    logic             w_pick_m1;
    logic             w_sel_we;
    logic [7:0]       w_sel_adr;
    logic [7:0]       w_sel_dat;
    logic             w_gnt_stb;
    logic [6:0]       w_slot_base;
    logic [7:0]       w_slot_dat;

    // r_last = 1 means m1 was granted last; on a tie the other master wins.
    assign w_pick_m1   = m1_stb_i & (~m0_stb_i | ~r_last);
    assign w_sel_we    = w_pick_m1 ? m1_we_i  : m0_we_i;
    assign w_sel_adr   = w_pick_m1 ? m1_adr_i : m0_adr_i;
    assign w_sel_dat   = w_pick_m1 ? m1_dat_i : m0_dat_i;
    assign w_gnt_stb   = r_grant[1] ? m1_stb_i : m0_stb_i;
    assign w_slot_base = {r_adr[7:4], 3'b000};
    assign w_slot_dat  = dat_i[w_slot_base +: 8];

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_grant  <= '0;
            r_stb    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '1;
            r_dat    <= '1;
            r_m0_dat <= '1;
            r_m0_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_dat <= '1;
            r_m1_ack <= 1'b0;
            r_m1_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_grant  <= w_grant_nxt;
            r_stb    <= w_stb_nxt;
            r_we     <= w_we_nxt;
            r_adr    <= w_adr_nxt;
            r_dat    <= w_dat_nxt;
            r_m0_dat <= w_m0_dat_nxt;
            r_m0_ack <= w_m0_ack_nxt;
            r_m0_err <= w_m0_err_nxt;
            r_m1_dat <= w_m1_dat_nxt;
            r_m1_ack <= w_m1_ack_nxt;
            r_m1_err <= w_m1_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_grant_nxt  = r_grant;
        w_stb_nxt    = r_stb;
        w_we_nxt     = r_we;
        w_adr_nxt    = r_adr;
        w_dat_nxt    = r_dat;
        w_m0_dat_nxt = r_m0_dat;
        w_m0_ack_nxt = 1'b0;
        w_m0_err_nxt = 1'b0;
        w_m1_dat_nxt = r_m1_dat;
        w_m1_ack_nxt = 1'b0;
        w_m1_err_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (m0_stb_i || m1_stb_i) begin
                    w_we_nxt    = w_sel_we;
                    w_adr_nxt   = w_sel_adr;
                    w_dat_nxt   = w_sel_dat;
                    w_grant_nxt = w_pick_m1 ? 2'b10 : 2'b01;
                    w_last_nxt  = w_pick_m1;
                    w_stb_nxt   = 16'(1) << w_sel_adr[7:4];
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Slave ack beats both abort and timeout on the same edge.
                if (ack_i) begin
                    if (r_grant[1]) begin
                        w_m1_dat_nxt = w_slot_dat;
                        w_m1_ack_nxt = 1'b1;
                    end else begin
                        w_m0_dat_nxt = w_slot_dat;
                        w_m0_ack_nxt = 1'b1;
                    end
                    w_stb_nxt   = '0;
                    w_we_nxt    = 1'b0;
                    w_grant_nxt = '0;
                    w_state_nxt = ST_DONE;
                end else if (!w_gnt_stb) begin
                    w_stb_nxt   = '0;
                    w_we_nxt    = 1'b0;
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    if (r_grant[1]) begin
                        w_m1_dat_nxt = '1;
                        w_m1_ack_nxt = 1'b1;
                        w_m1_err_nxt = 1'b1;
                    end else begin
                        w_m0_dat_nxt = '1;
                        w_m0_ack_nxt = 1'b1;
                        w_m0_err_nxt = 1'b1;
                    end
                    w_stb_nxt   = '0;
                    w_we_nxt    = 1'b0;
                    w_grant_nxt = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stb_o    = r_stb;
    assign we_o     = r_we;
    assign adr_o    = r_adr;
    assign dat_o    = r_dat;
    assign grant_o  = r_grant;
    assign m0_dat_o = r_m0_dat;
    assign m0_ack_o = r_m0_ack;
    assign m0_err_o = r_m0_err;
    assign m1_dat_o = r_m1_dat;
    assign m1_ack_o = r_m1_ack;
    assign m1_err_o = r_m1_err;

endmodule

// File: tb/tb_support_wb_arbiter.sv
// Scoreboard bench for support_wb_arbiter: stimulus queues expected bus cycles and
// master responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_support_wb_arbiter;

    logic         clk_i;
    logic         nreset_i;
    logic         m0_stb_i, m0_we_i;
    logic [7:0]   m0_adr_i, m0_dat_i;
    logic [7:0]   m0_dat_o;
    logic         m0_ack_o, m0_err_o;
    logic         m1_stb_i, m1_we_i;
    logic [7:0]   m1_adr_i, m1_dat_i;
    logic [7:0]   m1_dat_o;
    logic         m1_ack_o, m1_err_o;
    logic [15:0]  stb_o;
    logic         we_o;
    logic [7:0]   adr_o, dat_o;
    logic [127:0] dat_i;
    logic         ack_i;
    logic [1:0]   grant_o;

    support_wb_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i),
        .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .grant_o(grant_o)
    );

    typedef struct {
        logic [15:0] stb;
        logic        we;
        logic [7:0]  adr;
        logic [7:0]  dat;
        logic [1:0]  gnt;
        int          at;
    } bus_exp_t;

    typedef struct {
        int          m;
        logic [7:0]  dat;
        logic        err;
        int          lat;
    } rsp_exp_t;

    bus_exp_t q_bus[$];
    rsp_exp_t q_rsp[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ack_delay = 0;   // 0 = slave never acks

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_bus(input logic [15:0] stb, input logic we, input logic [7:0] adr,
                           input logic [7:0] dat, input logic [1:0] gnt, input int at);
        bus_exp_t e;
        e.stb = stb; e.we = we; e.adr = adr; e.dat = dat; e.gnt = gnt; e.at = at;
        q_bus.push_back(e);
    endtask

    task automatic exp_rsp(input int m, input logic [7:0] dat, input logic err, input int lat);
        rsp_exp_t e;
        e.m = m; e.dat = dat; e.err = err; e.lat = lat;
        q_rsp.push_back(e);
    endtask

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    // Slave model: ack_i is sampled at the edge ack_delay cycles after the strobe edge.
    initial begin
        int age;
        age   = 0;
        ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            ack_i = 1'b0;
            if (stb_o == '0) begin
                age = 0;
            end else begin
                age++;
                if (ack_delay > 0 && age == ack_delay) ack_i = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic [15:0] prev_stb;
        logic [7:0]  mdat0, mdat1;
        int          stb_cyc;
        bus_exp_t    b;
        rsp_exp_t    r;
        prev_stb = '0; mdat0 = 8'hff; mdat1 = 8'hff; stb_cyc = 0;
        forever begin
            @(negedge clk_i);
            if (!nreset_i) begin
                prev_stb = '0; mdat0 = 8'hff; mdat1 = 8'hff;
            end else begin
                if (stb_o != '0 && prev_stb == '0) begin
                    stb_cyc = cyc;
                    if (q_bus.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_unexpected: actual stb_o=%h required=none", stb_o);
                    end else begin
                        b = q_bus.pop_front();
                        chk("bus_onehot", $countones(stb_o), 1);
                        chk("bus_stb", stb_o, b.stb);
                        chk("bus_we", we_o, b.we);
                        chk("bus_adr", adr_o, b.adr);
                        chk("bus_dat", dat_o, b.dat);
                        chk("bus_grant", grant_o, b.gnt);
                        if (b.at >= 0) chk("bus_req_to_stb", cyc, b.at);
                    end
                end
                if (m0_ack_o || m1_ack_o) begin
                    if (q_rsp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: actual m0_ack=%0b m1_ack=%0b required=none",
                                 m0_ack_o, m1_ack_o);
                    end else begin
                        r = q_rsp.pop_front();
                        chk("rsp_master", {m1_ack_o, m0_ack_o}, (r.m == 1) ? 2'b10 : 2'b01);
                        chk("rsp_dat", (r.m == 1) ? m1_dat_o : m0_dat_o, r.dat);
                        chk("rsp_err", (r.m == 1) ? m1_err_o : m0_err_o, r.err);
                        chk("rsp_latency", cyc - stb_cyc, r.lat);
                        chk("rsp_other_dat", (r.m == 1) ? m0_dat_o : m1_dat_o,
                            (r.m == 1) ? mdat0 : mdat1);
                        chk("rsp_grant_cleared", grant_o, 2'b00);
                        if (r.m == 1) mdat1 = r.dat; else mdat0 = r.dat;
                    end
                end
                if ((m0_err_o && !m0_ack_o) || (m1_err_o && !m1_ack_o)) begin
                    checks++; errors++;
                    $display("FAIL err_without_ack: actual err=%0b%0b required=00", m1_err_o, m0_err_o);
                end
                prev_stb = stb_o;
            end
        end
    end

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // Raise a request and hold it until this master is acked (bounded).
    task automatic do_cycle(input int m, input logic we, input logic [7:0] adr, input logic [7:0] dat);
        bit got;
        got = 1'b0;
        if (m == 1) begin
            m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_stb_i = 1'b1;
        end else begin
            m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_stb_i = 1'b1;
        end
        for (int i = 0; i < 64; i++) begin
            sync();
            if ((m == 1) ? m1_ack_o : m0_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (m == 1) m1_stb_i = 1'b0; else m0_stb_i = 1'b0;
        chk($sformatf("ack_arrived_m%0d", m), {31'd0, got}, 32'd1);
    endtask

    initial begin
        nreset_i = 1'b0;
        m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0;
        m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0;
        // slot n read data = 8'h75 + 16*n  (slot 3 = A5)
        for (int n = 0; n < 16; n++) dat_i[8*n +: 8] = 8'h75 + 8'(n * 16);

        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset_stb", stb_o, 16'h0000);
        chk("reset_we", we_o, 1'b0);
        chk("reset_adr", adr_o, 8'hff);
        chk("reset_dat", dat_o, 8'hff);
        chk("reset_grant", grant_o, 2'b00);
        chk("reset_m0_dat", m0_dat_o, 8'hff);
        chk("reset_m1_dat", m1_dat_o, 8'hff);
        chk("reset_acks_errs", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
        nreset_i = 1'b1;
        repeat (2) sync();

        // m0 read 0x32, slot 3 acks after 2 cycles
        ack_delay = 2;
        exp_bus(16'h0008, 1'b0, 8'h32, 8'h00, 2'b01, cyc + 1);
        exp_rsp(0, 8'hA5, 1'b0, 2);
        do_cycle(0, 1'b0, 8'h32, 8'h00);
        repeat (2) sync();

        // m1 single read so that m1 is last granted
        ack_delay = 1;
        exp_bus(16'h0010, 1'b0, 8'h4A, 8'h00, 2'b10, cyc + 1);
        exp_rsp(1, 8'hB5, 1'b0, 1);
        do_cycle(1, 1'b0, 8'h4A, 8'h00);
        repeat (2) sync();

        // Simultaneous pair, m0 wins
        ack_delay = 1;
        exp_bus(16'h0002, 1'b1, 8'h10, 8'h55, 2'b01, cyc + 1);
        exp_rsp(0, 8'h85, 1'b0, 1);
        exp_bus(16'h0004, 1'b0, 8'h20, 8'h00, 2'b10, -1);
        exp_rsp(1, 8'h95, 1'b0, 1);
        fork
            do_cycle(0, 1'b1, 8'h10, 8'h55);
            do_cycle(1, 1'b0, 8'h20, 8'h00);
        join
        repeat (2) sync();

        // m0 single read so that m0 is last granted
        ack_delay = 3;
        exp_bus(16'h0040, 1'b0, 8'h67, 8'h00, 2'b01, cyc + 1);
        exp_rsp(0, 8'hD5, 1'b0, 3);
        do_cycle(0, 1'b0, 8'h67, 8'h00);
        repeat (2) sync();

        // Second simultaneous pair, m1 wins
        ack_delay = 2;
        exp_bus(16'h0200, 1'b1, 8'h92, 8'hC3, 2'b10, cyc + 1);
        exp_rsp(1, 8'h05, 1'b0, 2);
        exp_bus(16'h0100, 1'b1, 8'h81, 8'h3C, 2'b01, -1);
        exp_rsp(0, 8'hF5, 1'b0, 2);
        fork
            do_cycle(0, 1'b1, 8'h81, 8'h3C);
            do_cycle(1, 1'b1, 8'h92, 8'hC3);
        join
        repeat (2) sync();

        // Timeout on unpopulated slot 15
        ack_delay = 0;
        exp_bus(16'h8000, 1'b0, 8'hF0, 8'h00, 2'b10, cyc + 1);
        exp_rsp(1, 8'hff, 1'b1, 16);
        do_cycle(1, 1'b0, 8'hF0, 8'h00);
        repeat (2) sync();

        // Ack lands exactly on the timeout edge
        ack_delay = 16;
        exp_bus(16'h0020, 1'b0, 8'h5C, 8'h00, 2'b01, cyc + 1);
        exp_rsp(0, 8'hC5, 1'b0, 16);
        do_cycle(0, 1'b0, 8'h5C, 8'h00);
        repeat (2) sync();

        // m0 aborts mid-WAIT
        ack_delay = 0;
        exp_bus(16'h4000, 1'b0, 8'hE1, 8'h00, 2'b01, cyc + 1);
        m0_we_i = 1'b0; m0_adr_i = 8'hE1; m0_dat_i = 8'h00; m0_stb_i = 1'b1;
        repeat (3) sync();
        m0_stb_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("abort_stb_cleared", stb_o, 16'h0000);
        chk("abort_grant_cleared", grant_o, 2'b00);
        chk("abort_no_ack", {m0_ack_o, m0_err_o}, 2'b00);
        repeat (3) sync();
        ack_delay = 1;
        exp_bus(16'h0004, 1'b0, 8'h23, 8'h00, 2'b10, cyc + 1);
        exp_rsp(1, 8'h95, 1'b0, 1);
        do_cycle(1, 1'b0, 8'h23, 8'h00);
        repeat (2) sync();

        // Async reset during WAIT
        ack_delay = 0;
        exp_bus(16'h0080, 1'b0, 8'h7F, 8'h00, 2'b10, cyc + 1);
        m1_we_i = 1'b0; m1_adr_i = 8'h7F; m1_dat_i = 8'h00; m1_stb_i = 1'b1;
        repeat (3) sync();
        #2;
        nreset_i = 1'b0;
        #1;
        chk("midrst_stb", stb_o, 16'h0000);
        chk("midrst_grant", grant_o, 2'b00);
        chk("midrst_adr", adr_o, 8'hff);
        chk("midrst_dat", dat_o, 8'hff);
        chk("midrst_m0_dat", m0_dat_o, 8'hff);
        chk("midrst_m1_dat", m1_dat_o, 8'hff);
        chk("midrst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
        m1_stb_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        nreset_i = 1'b1;
        repeat (2) sync();

        // Fresh pair after reset: last_grant back to m1, so m0 first
        ack_delay = 1;
        exp_bus(16'h0002, 1'b0, 8'h11, 8'h00, 2'b01, cyc + 1);
        exp_rsp(0, 8'h85, 1'b0, 1);
        exp_bus(16'h0008, 1'b0, 8'h33, 8'h00, 2'b10, -1);
        exp_rsp(1, 8'hA5, 1'b0, 1);
        fork
            do_cycle(0, 1'b0, 8'h11, 8'h00);
            do_cycle(1, 1'b0, 8'h33, 8'h00);
        join

        repeat (5) sync();
        chk("bus_queue_drained", q_bus.size(), 0);
        chk("rsp_queue_drained", q_rsp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/support_wb_arbiter.md
Name: support_wb_arbiter

Overview:
- Shares the 16-slot support-IO Wishbone device bus between two masters:
  - m0: the Z80 bus bridge.
  - m1: the support microcontroller / DMA port.
- Picks one master with round-robin fairness.
- Decodes adr[7:4] into a one-hot slave strobe and routes ack/read data back to the granted master.
- Terminates hung cycles with a timeout and an error pulse, so a missing slave cannot stall either master.

Parameters:
TIMEOUT, 16, cycles in WAIT without ack_i before forced termination (legal range 2..255)
CNT_W, 8, width of the timeout counter (must hold TIMEOUT-1)

Ports:
clk_i  input  1  system clock, all logic on rising edge
nreset_i  input  1  asynchronous active-low reset
m0_stb_i  input  1  master 0 cycle request, held until m0_ack_o
m0_we_i  input  1  master 0 write enable
m0_adr_i  input  8  master 0 address ([7:4] slot, [3:0] register)
m0_dat_i  input  8  master 0 write data
m0_dat_o  output  8  master 0 read data, valid with m0_ack_o
m0_ack_o  output  1  master 0 one-cycle completion pulse
m0_err_o  output  1  master 0 timeout pulse, coincident with m0_ack_o
m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o  same as m0, for master 1
stb_o  output  16  one-hot slave strobe, bit = granted adr[7:4]
we_o  output  1  registered write enable
adr_o  output  8  registered address
dat_o  output  8  registered write data
dat_i  input  128  merged slave read data, slot n on bits [8n+7:8n]
ack_i  input  1  OR of slave acks
grant_o  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = idle)

Behaviour:
- Reset (async, nreset_i low):
  - stb_o=0, we_o=0, adr_o=8'hff, dat_o=8'hff, grant_o=0.
  - All m*_ack_o, m*_err_o = 0; m*_dat_o = 8'hff.
  - FSM = IDLE, timeout counter = 0, last_grant = m1 (so m0 wins the first tie).
  - Reset asserted mid-cycle abandons the cycle; no ack is issued to either master.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If any m*_stb_i is sampled high at edge N, select a winner:
    - Only one requesting: that master wins.
    - Both requesting: the master not equal to last_grant wins.
  - At edge N, register the winner's we/adr/dat and set grant_o and last_grant.
  - At edge N, set stb_o[adr[7:4]]=1, clear the counter, and go to WAIT.
  - Slave sees the strobe one cycle after the request.
- WAIT:
  - ack_i high at an edge (a completion edge):
    - Capture dat_i slot adr_o[7:4] into the granted m*_dat_o.
    - Pulse the granted m*_ack_o for exactly one cycle.
    - Clear stb_o and we_o at that same edge and go to DONE.
  - No ack_i and counter == TIMEOUT-1 (also a completion edge):
    - Set granted m*_dat_o = 8'hff.
    - Pulse m*_ack_o and m*_err_o together.
    - Clear stb_o and go to DONE.
  - Otherwise the counter increments.
  - ack_i and timeout on the same edge: ack wins, err_o stays 0, real data is returned.
  - Granted master drops stb before ack (abort): clear stb_o next edge, return to IDLE, no ack/err pulse.
- DONE:
  - One idle cycle; ack/err pulses clear, grant_o=0.
  - Stale stb still high from the just-served master is ignored this cycle.
  - Return to IDLE.
  - Minimum spacing between slave strobes is therefore 3 cycles.
- ack_i in IDLE or DONE is ignored.
- stb_o is always one-hot or zero, never multi-hot.
- adr_o/dat_o hold their last value when idle.
- Non-granted master's ack/err/dat outputs never change.
- Counter never wraps: it saturates at TIMEOUT-1, and the FSM leaves WAIT at that value.

Test Plan:
- Reset then m0 read adr 8'h32, slot 3 returns 8'hA5, ack_i 2 cycles after stb_o[3] -> stb_o=16'h0008 one cycle after request; m0_dat_o=8'hA5 with a 1-cycle m0_ack_o; m0_err_o=0.
- m0 and m1 both request from idle (m0 write 8'h10<-8'h55, m1 read 8'h20) -> m0 served first (stb_o bit1, we_o=1, dat_o=8'h55); then m1 (stb_o bit2). A second simultaneous pair is served m1-first.
- m1 read of unpopulated slot 8'hF0, ack_i never asserted, TIMEOUT=16 -> m1_ack_o and m1_err_o pulse together 16 cycles after stb_o[15] rises; m1_dat_o=8'hff; stb_o cleared.
- ack_i on exactly the timeout edge -> ack_o pulses, err_o stays 0, slave data delivered.
- m0 drops stb mid-WAIT -> stb_o clears next edge, no m0_ack_o; next m1 request is granted normally.
- nreset_i pulsed low during WAIT -> all outputs at reset values immediately (async); no ack; a fresh request afterwards completes normally.
